alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Upstream issue stage for the 8-bit ALU (operands A/B, 3-bit mode, 16-bit result).
- Buffers operand/mode commands in a small FIFO and drives the ALU operand inputs from registers, one command at a time.
- Captures the ALU's combinational 16-bit result and presents it downstream with a valid/ready handshake.
- Decouples the command producer and the result consumer from the ALU's fixed single-operation interface.

Parameters:
- DATA_W, 8, ALU operand width.
- MODE_W, 3, ALU mode select width.
- DEPTH, 4, command FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO can accept
- cmd_a  in  DATA_W  operand A
- cmd_b  in  DATA_W  operand B
- cmd_mode  in  MODE_W  ALU mode
- alu_a  out  DATA_W  registered operand A to the ALU
- alu_b  out  DATA_W  registered operand B to the ALU
- alu_mode  out  MODE_W  registered mode to the ALU
- alu_result  in  2*DATA_W  combinational ALU result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_data  out  2*DATA_W  captured result
- res_mode  out  MODE_W  mode that produced res_data
- count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset values: count=0, FIFO pointers=0, state=IDLE, alu_a/alu_b/alu_mode=0, res_valid=0, res_data=0, res_mode=0.
- cmd_ready: equals rst_n AND (count<DEPTH). It has no combinational path from res_ready.
- Push: occurs on any edge where cmd_valid && cmd_ready. Pointers wrap modulo DEPTH.
- Simultaneous push and pop: count is unchanged. A push into an empty FIFO is not visible to a pop on the same edge (no bypass).
- IDLE state:
  - If count>0, pop the head into alu_a/alu_b/alu_mode and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE state (exactly one cycle, lets the ALU settle):
  - On the next edge, res_data<=alu_result, res_mode<=alu_mode, res_valid<=1.
  - Go to HOLD.
- HOLD state:
  - res_data, res_mode and alu_* are held stable while res_valid && !res_ready.
  - On the handshake edge, res_valid<=0.
  - If count>0 on that edge, pop the next command and go to ISSUE; otherwise go to IDLE.
- Latency: res_valid rises 2 edges after the acceptance edge when the FIFO is empty and the state is IDLE.
- Throughput: 1 result per 2 cycles with res_ready held high.
- Ordering: results are produced strictly in command order. No command is dropped or duplicated.
- Mode values pass through unchanged, including unused codes. The sequencer does not interpret mode.
- Reset mid-operation: queued commands and any pending result are discarded. The next cycle after reset shows the reset values.

Optional Feature:
- Macro ALU_CMD_BYPASS_EN.
- Defined: in IDLE with count==0, an accepted command loads alu_a/alu_b/alu_mode directly on the acceptance edge, skips the FIFO, and goes to ISSUE. res_valid rises 1 edge after acceptance. count stays 0.
- Undefined: all commands pass through the FIFO, with the 2-edge latency above.

Decomposition:
- Package alu_pkg:
  - DATA_W, MODE_W, RES_W=2*DATA_W.
  - State encoding IDLE/ISSUE/HOLD.
  - Command struct {a, b, mode}.
- Sub-module alu_cmd_fifo: synchronous FIFO holding the command struct, with push/pop/count/full/empty.
- The top level holds the FSM, the ALU-facing registers and the result registers.
- The bench instantiates the existing ALU between alu_a/alu_b/alu_mode and alu_result.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> res_valid=0, count=0, alu_a=0, cmd_ready=0. Release -> cmd_ready=1.
- Single command: A=0x33, B=0x44, mode=0 accepted at edge E0 with res_ready=1 -> alu_a=0x33 after E1; res_valid=1 after E2; res_data equals the ALU output for (0x33,0x44,0); res_mode=0.
- Burst: modes 0,1,2,3,4,5,7 with A=0x33, B=0x44 back-to-back and res_ready=1 -> cmd_ready drops when count=4; 7 results arrive in order, one every 2 cycles, each matching the ALU model.
- Backpressure: res_ready=0 for 10 cycles with 5 commands offered -> res_data is stable; count saturates at 4; cmd_ready=0. Then res_ready=1 -> all 5 results drain in order.
- Reset mid-burst: rst_n=0 while in HOLD with count=3 -> the next cycle has res_valid=0 and count=0; no stale result appears after release.
- Bypass (ALU_CMD_BYPASS_EN): A=0xFF, B=0x01, mode=1 into an empty, idle sequencer -> res_valid after 1 edge; count stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, FSM state encoding and command payload for the ALU command sequencer.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned MODE_W = 3;
  localparam int unsigned RES_W  = 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [MODE_W-1:0] mode;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-facing and result signals of the sequencer; master = producer/ALU/consumer side.
interface alu_cmd_sequencer_if #(
  parameter int unsigned DEPTH = 4
);
  import alu_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [MODE_W-1:0] cmd_mode;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [MODE_W-1:0] alu_mode;
  logic [RES_W-1:0]  alu_result;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic [MODE_W-1:0] res_mode;
  logic [CNT_W-1:0]  count;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_mode, alu_result, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_mode, res_valid, res_data, res_mode, count
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_mode, alu_result, res_ready,
    output cmd_ready, alu_a, alu_b, alu_mode, res_valid, res_data, res_mode, count
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap modulo DEPTH, no same-edge bypass from push to pop.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  cmd_t                         din,
  input  logic                         pop,
  output cmd_t                         dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  cmd_t             mem_q [DEPTH];
  cmd_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_c, pop_ok_c;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign dout      = mem_q[rd_ptr_q];
  assign push_ok_c = push & ~full;
  assign pop_ok_c  = pop & ~empty;

  // Pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = mem_q[i];
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit ALU: queues commands, drives registered operands, captures results.
// Optional ALU_CMD_BYPASS_EN: a command into an idle, empty sequencer skips the FIFO.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_cmd_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [MODE_W-1:0] alu_mode_q, alu_mode_d;
  logic              res_valid_q, res_valid_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic [MODE_W-1:0] res_mode_q, res_mode_d;

  cmd_t              cmd_in_c;
  cmd_t              fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic              push_c, fifo_push_c, pop_c, bypass_c, res_hs_c;

  assign cmd_in_c     = '{a: bus.cmd_a, b: bus.cmd_b, mode: bus.cmd_mode};
  assign bus.cmd_ready = rst_n & ~fifo_full;
  assign push_c       = bus.cmd_valid & bus.cmd_ready;
  assign res_hs_c     = res_valid_q & bus.res_ready;

`ifdef ALU_CMD_BYPASS_EN
  assign bypass_c = (state_q == ST_IDLE) & fifo_empty & push_c;
`else
  assign bypass_c = 1'b0;
`endif

  assign fifo_push_c = push_c & ~bypass_c;
  assign pop_c       = ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & res_hs_c)) & ~fifo_empty;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_c),
    .din   (cmd_in_c),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ISSUE is a single settle cycle for the ALU; HOLD waits for the consumer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty || bypass_c) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_HOLD;
      ST_HOLD:  if (res_hs_c) state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_mode_d  = alu_mode_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_mode_d  = res_mode_q;
    if (pop_c) begin
      alu_a_d    = fifo_dout.a;
      alu_b_d    = fifo_dout.b;
      alu_mode_d = fifo_dout.mode;
    end else if (bypass_c) begin
      alu_a_d    = bus.cmd_a;
      alu_b_d    = bus.cmd_b;
      alu_mode_d = bus.cmd_mode;
    end
    if (state_q == ST_ISSUE) begin
      res_data_d  = bus.alu_result;
      res_mode_d  = alu_mode_q;
      res_valid_d = 1'b1;
    end else if (res_hs_c) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_mode_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_mode_q  <= '0;
    end else begin
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_mode_q  <= alu_mode_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_mode_q  <= res_mode_d;
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_mode  = alu_mode_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_mode  = res_mode_q;
  assign bus.count     = fifo_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: ALU model on the operand bus, in-order scoreboard, directed and random phases.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

`ifdef ALU_CMD_BYPASS_EN
  localparam int EXP_LAT       = 1;
  localparam int EXP_CNT0      = 0;
  localparam int EXP_BURST_MAX = 3;
`else
  localparam int EXP_LAT       = 2;
  localparam int EXP_CNT0      = 1;
  localparam int EXP_BURST_MAX = 4;
`endif

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  mode;
    logic [15:0] res;
  } vec_t;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  mode;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.DEPTH(4)) bus ();

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference ALU sitting between the operand registers and alu_result
  function automatic logic [15:0] alu_f(logic [7:0] a, logic [7:0] b, logic [2:0] m);
    case (m)
      3'd0:    return 16'(a) + 16'(b);
      3'd1:    return 16'(a) - 16'(b);
      3'd2:    return 16'(a) * 16'(b);
      3'd3:    return {8'h00, a & b};
      3'd4:    return {8'h00, a | b};
      3'd5:    return {8'h00, a ^ b};
      3'd6:    return {a, b};
      default: return {8'h00, ~a};
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_mode);

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc    = 0;
  logic        last_acc;
  exp_t        exp_q[$];
  int unsigned hs_cyc[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample at negedge, update the scoreboard, return 1 unit after posedge
  task automatic step();
    logic acc, hs;
    @(negedge clk);
    acc = bus.cmd_valid && bus.cmd_ready;
    hs  = bus.res_valid && bus.res_ready;
    if (!rst_n) begin
      exp_q.delete();
      acc = 1'b0;
    end else if (bus.res_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_unexpected: got data 0x%0h mode %0d with no command outstanding", bus.res_data, bus.res_mode);
      end else begin
        chk("sb_data", 32'(bus.res_data), 32'(exp_q[0].data));
        chk("sb_mode", 32'(bus.res_mode), 32'(exp_q[0].mode));
        if (hs) begin
          void'(exp_q.pop_front());
          hs_cyc.push_back(cyc);
        end
      end
    end
    if (acc) exp_q.push_back('{data: alu_f(bus.cmd_a, bus.cmd_b, bus.cmd_mode), mode: bus.cmd_mode});
    last_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  vec_t       tbl[12];
  logic [2:0] bmodes[7];
  int         idx;
  int         max_cnt;

  initial begin
    tbl[0]  = '{8'h33, 8'h44, 3'd0, 16'h0077};
    tbl[1]  = '{8'h33, 8'h44, 3'd1, 16'hFFEF};
    tbl[2]  = '{8'h33, 8'h44, 3'd2, 16'h0D8C};
    tbl[3]  = '{8'h33, 8'h44, 3'd3, 16'h0000};
    tbl[4]  = '{8'h33, 8'h44, 3'd4, 16'h0077};
    tbl[5]  = '{8'h33, 8'h44, 3'd5, 16'h0077};
    tbl[6]  = '{8'h33, 8'h44, 3'd6, 16'h3344};
    tbl[7]  = '{8'h33, 8'h44, 3'd7, 16'h00CC};
    tbl[8]  = '{8'hFF, 8'h01, 3'd0, 16'h0100};
    tbl[9]  = '{8'hFF, 8'h01, 3'd1, 16'h00FE};
    tbl[10] = '{8'hFF, 8'hFF, 3'd2, 16'hFE01};
    tbl[11] = '{8'h00, 8'h01, 3'd1, 16'hFFFF};
    bmodes  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_mode = '0;
    bus.res_ready = 1'b0;

    // Reset values
    step();
    step();
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Table: single command into an idle sequencer, latency and value
    bus.res_ready = 1'b1;
    foreach (tbl[i]) begin
      bus.cmd_a = tbl[i].a;
      bus.cmd_b = tbl[i].b;
      bus.cmd_mode = tbl[i].mode;
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      chk("tbl_accept", 32'(last_acc), 32'd1);
      chk("tbl_count_e0", 32'(bus.count), 32'(EXP_CNT0));
      chk("tbl_valid_e0", 32'(bus.res_valid), 32'd0);
      for (int k = 1; k < EXP_LAT; k++) begin
        step();
        chk("tbl_valid_early", 32'(bus.res_valid), 32'd0);
        chk("tbl_alu_a_e1", 32'(bus.alu_a), 32'(tbl[i].a));
      end
      step();
      chk("tbl_valid", 32'(bus.res_valid), 32'd1);
      chk("tbl_res_data", 32'(bus.res_data), 32'(tbl[i].res));
      chk("tbl_res_mode", 32'(bus.res_mode), 32'(tbl[i].mode));
      chk("tbl_alu_b", 32'(bus.alu_b), 32'(tbl[i].b));
      chk("tbl_count", 32'(bus.count), 32'd0);
      step();
      chk("tbl_valid_drop", 32'(bus.res_valid), 32'd0);
    end

    // Burst: back-to-back commands, one result every two cycles
    hs_cyc.delete();
    idx = 0;
    max_cnt = 0;
    for (int n = 0; n < 60 && (idx < 7 || exp_q.size() > 0); n++) begin
      bus.cmd_valid = (idx < 7);
      bus.cmd_a = 8'h33;
      bus.cmd_b = 8'h44;
      bus.cmd_mode = bmodes[idx < 7 ? idx : 0];
      step();
      if (last_acc) idx++;
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      if (int'(bus.count) == 4) chk("burst_full_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    chk("burst_accepted", 32'(idx), 32'd7);
    chk("burst_drained", 32'(exp_q.size()), 32'd0);
    chk("burst_max_count", 32'(max_cnt), 32'(EXP_BURST_MAX));
    chk("burst_results", 32'(hs_cyc.size()), 32'd7);
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("burst_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);

    // Backpressure: consumer stalls while five commands are offered
    bus.res_ready = 1'b0;
    idx = 0;
    for (int n = 0; n < 10; n++) begin
      bus.cmd_valid = (idx < 5);
      bus.cmd_a = 8'($urandom);
      bus.cmd_b = 8'($urandom);
      bus.cmd_mode = 3'($urandom);
      step();
      if (last_acc) idx++;
    end
    bus.cmd_valid = 1'b0;
    chk("bp_accepted", 32'(idx), 32'd5);
    chk("bp_count", 32'(bus.count), 32'd4);
    chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
    bus.res_ready = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) step();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_count_end", 32'(bus.count), 32'd0);
    chk("bp_valid_end", 32'(bus.res_valid), 32'd0);

    // Reset while holding a result with three commands queued
    bus.res_ready = 1'b0;
    idx = 0;
    for (int n = 0; n < 8; n++) begin
      bus.cmd_valid = (idx < 4);
      bus.cmd_a = 8'($urandom);
      bus.cmd_b = 8'($urandom);
      bus.cmd_mode = 3'($urandom);
      step();
      if (last_acc) idx++;
    end
    bus.cmd_valid = 1'b0;
    chk("mr_count_pre", 32'(bus.count), 32'd3);
    chk("mr_valid_pre", 32'(bus.res_valid), 32'd1);
    rst_n = 1'b0;
    step();
    chk("mr_res_valid", 32'(bus.res_valid), 32'd0);
    chk("mr_count", 32'(bus.count), 32'd0);
    chk("mr_alu_mode", 32'(bus.alu_mode), 32'd0);
    chk("mr_res_data", 32'(bus.res_data), 32'd0);
    chk("mr_res_mode", 32'(bus.res_mode), 32'd0);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      chk("mr_no_stale", 32'(bus.res_valid), 32'd0);
    end

    // Random traffic with occasional resets against the scoreboard
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 99) >= 2);
      bus.cmd_valid = ($urandom_range(0, 99) < 70);
      bus.cmd_a = 8'($urandom);
      bus.cmd_b = 8'($urandom);
      bus.cmd_mode = 3'($urandom);
      bus.res_ready = ($urandom_range(0, 99) < 60);
      step();
    end
    rst_n = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) step();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_count_end", 32'(bus.count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
